// File: rtl/nlynx_snapshot_fifo.sv
// Captures all metric counters plus overflow flags on each rising edge of eop_i into a frame buffer.
// Latency: capture at edge N, header word valid after edge N+1; M+1 beats per frame, no inter-frame bubble.
// Backpressure: m_tready_i stalls the stream; a capture into a full buffer is dropped and counted.
module nlynx_snapshot_fifo #(
    parameter int NLYNX_METRICS       = 13,
    parameter int NLYNX_COUNTER_WIDTH = 32,
    parameter int DEPTH               = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    input  logic                                          eop_i,
    input  logic [NLYNX_METRICS-1:0]                      overflow_i,
    input  logic [NLYNX_METRICS*NLYNX_COUNTER_WIDTH-1:0]  cnt_i,
    output logic [31:0]                                   m_tdata_o,
    output logic                                          m_tvalid_o,
    input  logic                                          m_tready_i,
    output logic                                          m_tlast_o,
    output logic [$clog2(DEPTH+1)-1:0]                    frames_pending_o,
    output logic [15:0]                                   drop_cnt_o
);

    localparam int M   = NLYNX_METRICS;
    localparam int W   = NLYNX_COUNTER_WIDTH;
    localparam int NW  = M + 1;
    localparam int WIW = $clog2(NW);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);

    localparam logic [WIW-1:0] LAST_IDX = WIW'(M);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           eop_q;
    logic [15:0]    seq;
    logic [15:0]    drop_cnt;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [WIW-1:0] word_idx;

    logic           capture;
    logic           push;
    logic           pop;
    logic           drop;

    logic [31:0]    frame [NW];
    logic [31:0]    mem   [DEPTH][NW];

    // A capture is any rising edge of eop_i; flush suppresses its effects.
    assign capture = eop_i & ~eop_q;
    // The final word handshake frees the slot being read.
    assign pop     = (state == S_SEND) & m_tready_i & (word_idx == LAST_IDX);
    // A pop in the same cycle makes room, so a full buffer can still accept.
    assign push    = capture & ~flush_i & ((count != FULL_CNT) | pop);
    assign drop    = capture & ~flush_i & ~push;

    // Assemble the frame from the live inputs: header then zero-extended counters.
    always_comb begin
        for (int k = 0; k < NW; k++) begin
            frame[k] = '0;
        end
        frame[0][31:16] = seq;
        frame[0][M-1:0] = overflow_i;
        for (int k = 0; k < M; k++) begin
            frame[k+1][W-1:0] = cnt_i[k*W +: W];
        end
    end

    // Frame storage; contents need no reset because count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int k = 0; k < NW; k++) begin
                mem[wr_ptr][k] <= frame[k];
            end
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Edge detector history; tracks eop_i even during flush so a held level never re-triggers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eop_q <= 1'b0;
        end else begin
            eop_q <= eop_i;
        end
    end

    // Buffer pointers and frame count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

    // Word position within the frame being streamed; wraps to the header after the last word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_idx <= '0;
        end else if (flush_i) begin
            word_idx <= '0;
        end else if ((state == S_SEND) && m_tready_i) begin
            if (pop) begin
                word_idx <= '0;
            end else begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

    // Sequence number advances on every capture, dropped or not, so gaps are visible downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq <= '0;
        end else if (flush_i) begin
            seq <= '0;
        end else if (capture) begin
            seq <= seq + 16'd1;
        end
    end

    // Saturating count of frames lost to a full buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
        end else if (flush_i) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Readout FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Readout FSM next state: stay in SEND across back-to-back frames to avoid bubbles.
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state_nxt = S_SEND;
                    end
                end
                S_SEND: begin
                    if (pop && (count_nxt == '0)) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Stream outputs depend only on registered state, never on m_tready_i.
    always_comb begin
        m_tvalid_o = (state == S_SEND);
        m_tlast_o  = 1'b0;
        m_tdata_o  = '0;
        if (state == S_SEND) begin
            m_tlast_o = (word_idx == LAST_IDX);
            m_tdata_o = mem[rd_ptr][word_idx];
        end
    end

    assign frames_pending_o = count;
    assign drop_cnt_o       = drop_cnt;

endmodule

// File: tb/tb_nlynx_snapshot_fifo.sv
// Self-checking bench for nlynx_snapshot_fifo with an expected-word scoreboard.
// Latency: expected words queued at capture, compared at each valid&ready beat.
// Backpressure: ready is toggled and held low to exercise stalls and buffer overflow.
module tb_nlynx_snapshot_fifo;

    localparam int M = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              flush;
    logic              eop;
    logic              ready;
    logic [M-1:0]      ovf;
    logic [M*32-1:0]   cnt;
    logic [31:0]       tdata;
    logic              tvalid;
    logic              tlast;
    logic [2:0]        pending;
    logic [15:0]       drop;

    logic              flush20;
    logic              eop20;
    logic              ready20;
    logic [M-1:0]      ovf20;
    logic [M*20-1:0]   cnt20;
    logic [31:0]       tdata20;
    logic              tvalid20;
    logic              tlast20;
    logic [2:0]        pending20;
    logic [15:0]       drop20;

    nlynx_snapshot_fifo #(.NLYNX_METRICS(M), .NLYNX_COUNTER_WIDTH(32), .DEPTH(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .eop_i(eop),
        .overflow_i(ovf), .cnt_i(cnt),
        .m_tdata_o(tdata), .m_tvalid_o(tvalid), .m_tready_i(ready), .m_tlast_o(tlast),
        .frames_pending_o(pending), .drop_cnt_o(drop)
    );

    nlynx_snapshot_fifo #(.NLYNX_METRICS(M), .NLYNX_COUNTER_WIDTH(20), .DEPTH(4)) u_dut20 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush20), .eop_i(eop20),
        .overflow_i(ovf20), .cnt_i(cnt20),
        .m_tdata_o(tdata20), .m_tvalid_o(tvalid20), .m_tready_i(ready20), .m_tlast_o(tlast20),
        .frames_pending_o(pending20), .drop_cnt_o(drop20)
    );

    int          total = 0;
    int          bad   = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp20_q[$];
    logic [15:0] seq_m = 16'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue the words of one frame {tlast, data}, using the model sequence number.
    task automatic push_frame(input logic [M-1:0] o, input logic [31:0] base);
        exp_q.push_back({1'b0, seq_m, 16'(o)});
        for (int k = 0; k < M; k++) begin
            exp_q.push_back({(k == M - 1), base + 32'(k)});
        end
    endtask

    task automatic set_inputs(input logic [M-1:0] o, input logic [31:0] base);
        ovf = o;
        for (int k = 0; k < M; k++) begin
            cnt[k*32 +: 32] = base + 32'(k);
        end
    endtask

    // One eop pulse plus a low cycle so the next pulse is a fresh rising edge.
    task automatic do_capture(input logic [M-1:0] o, input logic [31:0] base, input bit accept);
        set_inputs(o, base);
        eop = 1'b1;
        if (accept) push_frame(o, base);
        seq_m = seq_m + 16'd1;
        @(posedge clk); #1;
        eop = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: stability under stall, then scoreboard compare on each handshake.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic        prev_f = 1'b0;
    logic [32:0] prev_d = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_v && !prev_r && !prev_f) begin
                chk("hold_valid", 64'(tvalid), 64'd1);
                chk("hold_data", 64'({tlast, tdata}), 64'(prev_d));
            end
            if (tvalid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("word", 64'({tlast, tdata}), 64'(exp_q.pop_front()));
                end
            end
        end
        prev_v = tvalid;
        prev_r = ready;
        prev_f = flush;
        prev_d = {tlast, tdata};
    end

    always @(negedge clk) begin
        if (rst_n && tvalid20 && ready20) begin
            if (exp20_q.size() == 0) begin
                chk("spurious20", 64'(exp20_q.size()), 64'd1);
            end else begin
                chk("word20", 64'({tlast20, tdata20}), 64'(exp20_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; eop = 1'b0; ready = 1'b1; ovf = '0; cnt = '0;
        flush20 = 1'b0; eop20 = 1'b0; ready20 = 1'b1; ovf20 = '0; cnt20 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(tvalid), 64'd0);
        chk("rst_last", 64'(tlast), 64'd0);
        chk("rst_data", 64'(tdata), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single capture with exact first-word timing.
        set_inputs(13'h0005, 32'h1000);
        eop = 1'b1;
        push_frame(13'h0005, 32'h1000);
        seq_m = seq_m + 16'd1;
        @(posedge clk); #1;
        eop = 1'b0;
        chk("n_valid", 64'(tvalid), 64'd0);
        chk("n_pending", 64'(pending), 64'd1);
        @(posedge clk); #1;
        chk("n1_valid", 64'(tvalid), 64'd1);
        chk("n1_header", 64'(tdata), 64'h0000_0005);
        wait_drain(40);
        @(posedge clk); #1;
        chk("idle_valid", 64'(tvalid), 64'd0);
        chk("idle_pending", 64'(pending), 64'd0);

        // Backpressure: ready toggles every cycle.
        set_inputs(13'h0A5A, 32'h2000);
        eop = 1'b1;
        push_frame(13'h0A5A, 32'h2000);
        seq_m = seq_m + 16'd1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
            eop = 1'b0;
            ready = ~ready;
        end
        chk("bp_drain", 64'(exp_q.size()), 64'd0);
        ready = 1'b1;
        @(posedge clk); #1;

        // Buffer overflow: six captures while stalled, only four fit.
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_capture(M'(i + 1), 32'h3000 + 32'(i) * 32'h100, (i < 4));
        end
        chk("ovf_pending", 64'(pending), 64'd4);
        chk("ovf_drop", 64'(drop), 64'd2);

        // Capture coincides with the final-word pop of a full buffer.
        ready = 1'b1;
        for (int i = 0; i < 40 && !tlast; i++) begin
            @(posedge clk); #1;
        end
        chk("tlast_seen", 64'(tlast), 64'd1);
        set_inputs(13'h1FFF, 32'h4000);
        eop = 1'b1;
        push_frame(13'h1FFF, 32'h4000);
        seq_m = seq_m + 16'd1;
        @(posedge clk); #1;
        eop = 1'b0;
        chk("popush_pending", 64'(pending), 64'd4);
        chk("popush_drop", 64'(drop), 64'd2);
        wait_drain(200);
        @(posedge clk); #1;
        chk("full_drain_pending", 64'(pending), 64'd0);
        chk("full_drain_valid", 64'(tvalid), 64'd0);

        // eop held high: a single capture only.
        set_inputs(13'h0003, 32'h5000);
        eop = 1'b1;
        push_frame(13'h0003, 32'h5000);
        seq_m = seq_m + 16'd1;
        repeat (100) begin
            @(posedge clk); #1;
        end
        eop = 1'b0;
        @(posedge clk); #1;
        wait_drain(50);
        @(posedge clk); #1;
        chk("held_pending", 64'(pending), 64'd0);
        chk("held_drop", 64'(drop), 64'd2);

        // Flush while word 5 is presented.
        set_inputs(13'h0011, 32'h6000);
        eop = 1'b1;
        push_frame(13'h0011, 32'h6000);
        seq_m = seq_m + 16'd1;
        @(posedge clk); #1;
        eop = 1'b0;
        for (int i = 0; i < 10 && !tvalid; i++) begin
            @(posedge clk); #1;
        end
        chk("fl_valid_seen", 64'(tvalid), 64'd1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("fl_word5", 64'(tdata), 64'h0000_6004);
        ready = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_valid", 64'(tvalid), 64'd0);
        chk("fl_pending", 64'(pending), 64'd0);
        chk("fl_drop", 64'(drop), 64'd0);
        exp_q.delete();
        seq_m = 16'd0;
        ready = 1'b1;
        set_inputs(13'h0002, 32'h7000);
        eop = 1'b1;
        push_frame(13'h0002, 32'h7000);
        seq_m = seq_m + 16'd1;
        @(posedge clk); #1;
        eop = 1'b0;
        @(posedge clk); #1;
        chk("fl_hdr", 64'(tdata), 64'h0000_0002);
        wait_drain(50);

        // 20-bit counters are zero-extended to 32 bits.
        ovf20 = 13'h1FFF;
        for (int k = 0; k < M; k++) begin
            cnt20[k*20 +: 20] = 20'hFFFFF - 20'(k);
        end
        exp20_q.push_back({1'b0, 32'h0000_1FFF});
        for (int k = 0; k < M; k++) begin
            exp20_q.push_back({(k == M - 1), 32'h000F_FFFF - 32'(k)});
        end
        eop20 = 1'b1;
        @(posedge clk); #1;
        eop20 = 1'b0;
        for (int i = 0; i < 40 && exp20_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("w20_drain", 64'(exp20_q.size()), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_left", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
